// File: rtl/inv_mix_columns_seq.sv
// Sequential AES (Inv)MixColumns: captures a 128-bit state, transforms COLS_PER_CYCLE columns per cycle.
// Optional macro INV_MIX_COLUMNS_FWD_EN adds a 'fwd' port selecting the forward MixColumns matrix.

package inv_mix_columns_seq_pkg;
  // Byte i of the state is element [i]; column c is bytes 4c..4c+3, row r is byte 4c+r.
  typedef logic [15:0][7:0] state_t;
  typedef logic [3:0][7:0]  column_t;
endpackage

module inv_mix_columns_seq
  import inv_mix_columns_seq_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t in_state,
`ifdef INV_MIX_COLUMNS_FWD_EN
  input  logic   fwd,
`endif
  output logic   out_valid,
  input  logic   out_ready,
  output state_t out_state
);

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned CNT_W    = 2;
  localparam logic [CNT_W-1:0] STEP     = CNT_W'(COLS_PER_CYCLE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_COLS - COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  fsm_t             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           data_q, data_d, data_mix;
  logic [3:0]       col_base;
  logic             in_ready_q, out_valid_q;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Row r uses (14 11 13 9) rotated right by r
  function automatic column_t inv_col(input column_t c);
    column_t o;
    for (int r = 0; r < 4; r++) begin
      o[2'(r)] = mul14(c[2'(r)]) ^ mul11(c[2'(r + 1)]) ^
                 mul13(c[2'(r + 2)]) ^ mul9(c[2'(r + 3)]);
    end
    return o;
  endfunction

`ifdef INV_MIX_COLUMNS_FWD_EN
  logic fwd_q, fwd_d;

  function automatic column_t fwd_col(input column_t c);
    column_t o;
    for (int r = 0; r < 4; r++) begin
      o[2'(r)] = mul2(c[2'(r)]) ^ mul3(c[2'(r + 1)]) ^ c[2'(r + 2)] ^ c[2'(r + 3)];
    end
    return o;
  endfunction

  function automatic column_t mix_col(input column_t c, input logic f);
    return f ? fwd_col(c) : inv_col(c);
  endfunction
`else
  function automatic column_t mix_col(input column_t c, input logic f);
    return f ? c : inv_col(c);
  endfunction
`endif

  // Transform the columns addressed by the counter this cycle
  always_comb begin
    data_mix = data_q;
    col_base = '0;
    for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
      col_base = {cnt_q + CNT_W'(k), 2'b00};
`ifdef INV_MIX_COLUMNS_FWD_EN
      data_mix[col_base +: 4] = mix_col(data_q[col_base +: 4], fwd_q);
`else
      data_mix[col_base +: 4] = mix_col(data_q[col_base +: 4], 1'b0);
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef INV_MIX_COLUMNS_FWD_EN
    fwd_d   = fwd_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_state;
          cnt_d   = '0;
          state_d = BUSY;
`ifdef INV_MIX_COLUMNS_FWD_EN
          fwd_d   = fwd;
`endif
        end
      end
      BUSY: begin
        data_d = data_mix;
        cnt_d  = cnt_q + STEP;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

`ifdef INV_MIX_COLUMNS_FWD_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fwd_q <= 1'b0;
    end else begin
      fwd_q <= fwd_d;
    end
  end
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = data_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq at COLS_PER_CYCLE = 1, 2 and 4 sharing one clock and reset.
module tb_inv_mix_columns_seq;
  import inv_mix_columns_seq_pkg::*;

  logic   clock;
  logic   reset_n;
  logic   in_valid  [3];
  logic   in_ready  [3];
  state_t in_state  [3];
  logic   out_valid [3];
  logic   out_ready [3];
  state_t out_state [3];
`ifdef INV_MIX_COLUMNS_FWD_EN
  logic   fwd       [3];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
`ifdef INV_MIX_COLUMNS_FWD_EN
      .fwd       (fwd[g]),
`endif
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g])
    );
  end

  typedef struct {
    int     d;
    state_t st;
    state_t ex;
    int     lat;
  } vec_t;

  function automatic state_t mk_state(input logic [31:0] w0, input logic [31:0] w1,
                                      input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w [4];
    state_t s;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[4'(4 * c + r)] = w[c][8'(31 - 8 * r) -: 8];
    return s;
  endfunction

  // Reference: generic shift-and-add GF(2^8) multiply with an explicit coefficient matrix
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? (8'({x[6:0], 1'b0}) ^ 8'h1b) : 8'({x[6:0], 1'b0});
    end
    return p;
  endfunction

  function automatic state_t mix_model(input state_t s, input logic f);
    logic [7:0] row0 [4];
    state_t o;
    if (f) begin row0[0] = 8'd2;  row0[1] = 8'd3;  row0[2] = 8'd1;  row0[3] = 8'd1; end
    else   begin row0[0] = 8'd14; row0[1] = 8'd11; row0[2] = 8'd13; row0[3] = 8'd9; end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 4; j++)
          o[4'(4 * c + r)] = o[4'(4 * c + r)] ^ gmul(row0[(j - r + 4) % 4], s[4'(4 * c + j)]);
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Accept one state on DUT d, check latency and result, then consume it
  task automatic run_op(input int d, input state_t st, input state_t ex, input int lat,
                        input string tag);
    int n;
    in_state[d] = st;
    in_valid[d] = 1'b1;
    check({tag, " in_ready before accept"}, 128'(in_ready[d]), 128'(1));
    @(posedge clock); #1;
    in_valid[d] = 1'b0;
    in_state[d] = ~st;
    n = 0;
    while (!out_valid[d] && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, " latency"}, 128'(n), 128'(lat));
    check({tag, " result"}, out_state[d], ex);
    check({tag, " in_ready in DONE"}, 128'(in_ready[d]), 128'(0));
    out_ready[d] = 1'b1;
    @(posedge clock); #1;
    out_ready[d] = 1'b0;
    check({tag, " out_valid after consume"}, 128'(out_valid[d]), 128'(0));
    check({tag, " in_ready after consume"}, 128'(in_ready[d]), 128'(1));
  endtask

  state_t sa, ea, sb, eb, sc, ec, sd, ed;
  vec_t   vecs [8];

  initial begin
    int n;
    sa = mk_state(32'h8e4da1bc, 32'h0, 32'h0, 32'h0);
    ea = mk_state(32'hdb135345, 32'h0, 32'h0, 32'h0);
    sb = mk_state(32'h9fdc589d, 32'h9fdc589d, 32'h9fdc589d, 32'h9fdc589d);
    eb = mk_state(32'hf20a225c, 32'hf20a225c, 32'hf20a225c, 32'hf20a225c);
    sc = mk_state(32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c);
    ec = mix_model(sc, 1'b0);
    sd = mk_state(32'h0, 32'h0, 32'h0, 32'h8e4da1bc);
    ed = mk_state(32'h0, 32'h0, 32'h0, 32'hdb135345);

    vecs[0] = '{d: 0, st: sa, ex: ea, lat: 4};
    vecs[1] = '{d: 0, st: sb, ex: eb, lat: 4};
    vecs[2] = '{d: 1, st: sb, ex: eb, lat: 2};
    vecs[3] = '{d: 2, st: sb, ex: eb, lat: 1};
    vecs[4] = '{d: 0, st: sc, ex: ec, lat: 4};
    vecs[5] = '{d: 1, st: sc, ex: ec, lat: 2};
    vecs[6] = '{d: 2, st: sc, ex: ec, lat: 1};
    vecs[7] = '{d: 1, st: sa, ex: ea, lat: 2};

    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      in_state[i]  = '0;
`ifdef INV_MIX_COLUMNS_FWD_EN
      fwd[i]       = 1'b0;
`endif
    end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset in_ready d%0d", i), 128'(in_ready[i]), 128'(1));
      check($sformatf("reset out_valid d%0d", i), 128'(out_valid[i]), 128'(0));
      check($sformatf("reset out_state d%0d", i), out_state[i], '0);
    end

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].d, vecs[i].st, vecs[i].ex, vecs[i].lat, $sformatf("vec%0d", i));

    // Identity columns pass through unchanged
    check("passthrough cols 0-1", 128'(ec[7:0]), 128'(sc[7:0]));

    // Stall in DONE with a pending input
    in_state[0] = sa;
    in_valid[0] = 1'b1;
    @(posedge clock); #1;
    in_state[0] = sb;
    n = 0;
    while (!out_valid[0] && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("stall first latency", 128'(n), 128'(4));
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check($sformatf("stall out_valid c%0d", i), 128'(out_valid[0]), 128'(1));
      check($sformatf("stall out_state c%0d", i), out_state[0], ea);
      check($sformatf("stall in_ready c%0d", i), 128'(in_ready[0]), 128'(0));
    end
    out_ready[0] = 1'b1;
    @(posedge clock); #1;
    out_ready[0] = 1'b0;
    check("stall consume out_valid", 128'(out_valid[0]), 128'(0));
    check("stall pending not yet taken", 128'(in_ready[0]), 128'(1));
    @(posedge clock); #1;
    in_valid[0] = 1'b0;
    check("stall pending accepted", 128'(in_ready[0]), 128'(0));
    n = 0;
    while (!out_valid[0] && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("stall second latency", 128'(n), 128'(4));
    check("stall second result", out_state[0], eb);
    out_ready[0] = 1'b1;
    @(posedge clock); #1;
    out_ready[0] = 1'b0;

    // Abort mid-BUSY with reset
    in_state[0] = sb;
    in_valid[0] = 1'b1;
    @(posedge clock); #1;
    in_valid[0] = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    #1;
    check("abort out_valid", 128'(out_valid[0]), 128'(0));
    check("abort out_state cleared", out_state[0], '0);
    check("abort in_ready", 128'(in_ready[0]), 128'(1));
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_op(0, sd, ed, 4, "post-abort");

`ifdef INV_MIX_COLUMNS_FWD_EN
    fwd[0] = 1'b1;
    run_op(0, ea, sa, 4, "fwd single");
    fwd[1] = 1'b1;
    run_op(1, sc, mix_model(sc, 1'b1), 2, "fwd roundtrip a");
    fwd[1] = 1'b0;
    run_op(1, mix_model(sc, 1'b1), sc, 2, "fwd roundtrip b");
    fwd[0] = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
